// File: rtl/spi_regbank_pkg.sv
// ---------------------------------------------------------------------------
// spi_regbank_pkg
// Shared definitions for the SPI-slave register bank:
//   - state_e      : frame FSM states (IDLE, CMD, DATA)
//   - CMD_W        : command phase length in bits
//   - CMD_WR_BIT   : command bit that selects write (1) or read (0)
//   - MAX_REGS     : widest read-only mask the bank accepts (ADDR_W up to 7)
//   - ro_sel()     : tells whether register idx is read-only under a mask
// ---------------------------------------------------------------------------
package spi_regbank_pkg;

  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int MAX_REGS   = 128;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  // A set mask bit marks the register as read-only: its read value comes
  // from the core and SPI writes to it are dropped.
  function automatic logic ro_sel(input logic [MAX_REGS-1:0] mask,
                                  input logic [6:0]          idx);
    return mask[idx];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for one asynchronous SPI pin, followed by one more
// flop so that single-cycle rise/fall pulses can be produced in clk_i.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input pin
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
// RST_VAL is the idle level of the pin, so that leaving reset with the pin
// at its idle level does not produce a spurious edge.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Stages 0 and 1 are the metastability filter; stage 2 holds the previous
  // synchronised level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regbank.sv
// ---------------------------------------------------------------------------
// spi_regbank
// SPI mode-0 slave with a NUM_REGS x REG_W register file.
// Frame: 8-bit command (bit 7 = write, low ADDR_W bits = start address),
// then REG_W-bit data words, all MSB first.
// Ports:
//   clk, nrst              : system clock, asynchronous active-low reset
//   spi_cs_n, spi_clk      : chip select and SPI clock (asynchronous pins)
//   spi_mosi / spi_miso    : serial data in / out
//   spi_miso_oe            : pad enable, high while the frame is active
//   ro_i                   : read-only sources, slice i = [i*REG_W +: REG_W]
//   regs_o                 : writable register contents, read-only slices 0
//   wr_vld / wr_addr       : one-cycle commit pulse and its address
//   busy                   : high from synchronised cs fall to cs rise
// Configuration macro:
//   SPI_REGBANK_BURST_EN   : defined -> address auto-increments per word;
//                            undefined -> one data word per frame.
// ---------------------------------------------------------------------------
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int                  ADDR_W  = 3,
  parameter int                  REG_W   = 8,
  parameter logic [MAX_REGS-1:0] RO_MASK = 'h01
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           spi_cs_n,
  input  logic                           spi_clk,
  input  logic                           spi_mosi,
  output logic                           spi_miso,
  output logic                           spi_miso_oe,
  input  logic [(2**ADDR_W)*REG_W-1:0]   ro_i,
  output logic [(2**ADDR_W)*REG_W-1:0]   regs_o,
  output logic                           wr_vld,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic                           busy
);

  localparam int         NUM_REGS      = 2**ADDR_W;
  localparam logic [4:0] LAST_CMD_BIT  = 5'(CMD_W - 1);
  localparam logic [4:0] LAST_DATA_BIT = 5'(REG_W - 1);

  logic              cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [1:0]        mosi_sync_q;
  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [REG_W-2:0]  rx_q, rx_d;
  logic [REG_W-1:0]  rx_next;
  logic [REG_W-1:0]  tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              wr_en;
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [REG_W-1:0]  regs_q [NUM_REGS];
  logic [REG_W-1:0]  ro_arr [NUM_REGS];
  logic [REG_W-1:0]  rd_val;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk),
    .rst_ni (nrst),
    .d_i    (spi_cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (nrst),
    .d_i    (spi_clk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // mosi only needs the same two-flop delay as sclk so that the bit seen on
  // a synchronised rising edge is the one the master presented.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  // Word assembled including the bit being sampled right now; the MSB of a
  // finished word never needs storing, so rx_q is one bit narrower.
  assign rx_next = {rx_q, mosi_sync_q[1]};

  // Per-register views of the read-only inputs, and the value a read would
  // load into the tx shifter for the current address.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign ro_arr[i]                  = ro_i[i*REG_W +: REG_W];
    assign regs_o[i*REG_W +: REG_W]   = ro_sel(RO_MASK, 7'(i)) ? '0 : regs_q[i];
  end

  assign rd_val = ro_sel(RO_MASK, 7'(addr_q)) ? ro_arr[addr_q] : regs_q[addr_q];

  // Frame FSM and datapath next-state. Every word boundary resets the bit
  // counter; reads load the shifter on the first falling edge of a word and
  // shift on the rest. done_q stops all activity once the single word of a
  // non-burst frame is through. A cs rise overrides everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    done_d    = done_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;

    if (cs_fall) busy_d = 1'b1;
    if (cs_rise) busy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          tx_d      = '0;
          done_d    = 1'b0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d = rx_next[REG_W-2:0];
          if (bit_cnt_q == LAST_CMD_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            is_wr_d   = rx_next[CMD_WR_BIT];
            addr_d    = rx_next[ADDR_W-1:0];
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (!done_q) begin
          if (sclk_rise) begin
            rx_d = rx_next[REG_W-2:0];
            if (bit_cnt_q == LAST_DATA_BIT) begin
              bit_cnt_d = '0;
              wr_en     = is_wr_q && !ro_sel(RO_MASK, 7'(addr_q));
`ifdef SPI_REGBANK_BURST_EN
              addr_d    = addr_q + 1'b1;
`else
              done_d    = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          if (sclk_fall && !is_wr_q) begin
            tx_d = (bit_cnt_q == '0) ? rd_val : {tx_q[REG_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d = IDLE;
      tx_d    = '0;
    end
  end

  // State registers plus the register file. A commit lands in the cycle
  // after the synchronised last-bit rising edge, together with wr_vld.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_vld_q  <= wr_en;
      if (wr_en) begin
        regs_q[addr_q] <= rx_next;
        wr_addr_q      <= addr_q;
      end
    end
  end

  assign spi_miso    = (state_q == DATA && !is_wr_q && !done_q) ? tx_q[REG_W-1] : 1'b0;
  assign spi_miso_oe = busy_q;
  assign busy        = busy_q;
  assign wr_vld      = wr_vld_q;
  assign wr_addr     = wr_addr_q;

endmodule
